// File: rtl/intr_ctl.sv
// intr_ctl -- interrupt sequencer for a 6502-style core.
//
// Synchronises the NMI/IRQ pins, keeps the RESET/NMI pending flags and
// steers the decoder through the shared BRK/interrupt micro-sequence:
// forcing the BRK opcode, selecting the vector and the pushed B bit, and
// turning the stack pushes into reads for RESET.
//
// Optional feature macro: INTR_NMI_HIJACK_EN
//   Defined   : an NMI arriving during an IRQ/BRK sequence before the
//               vector-low cycle takes over that sequence (vector 0xFA).
//   Undefined : the sequence kind is fixed at entry; the NMI waits for the
//               next opcode fetch.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_nmi_n       NMI pin (async, falling-edge sensitive)
//   i_irq_n       IRQ pin (async, level sensitive)
//   i_iflag       status I bit, 1 masks IRQ
//   i_sync        opcode-fetch cycle
//   i_ready       CPU READY, 0 stalls sequence state
//   i_brk_op      fetched opcode is 0x00 (valid with i_sync)
//   i_vec_cycle   decoder is on the vector-low address cycle
//   i_vec_done    final cycle of the BRK/interrupt sequence
//   o_force_brk   substitute opcode 0x00 and inhibit PC increment
//   o_kind        active sequence: 0 none, 1 IRQ/BRK, 2 NMI, 3 RESET
//   o_vec_lo      vector low address byte
//   o_bflag       B bit for the pushed status
//   o_wr_inhibit  stack pushes become reads (RESET only)
module intr_ctl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_nmi_n,
  input  logic       i_irq_n,
  input  logic       i_iflag,
  input  logic       i_sync,
  input  logic       i_ready,
  input  logic       i_brk_op,
  input  logic       i_vec_cycle,
  input  logic       i_vec_done,
  output logic       o_force_brk,
  output logic [1:0] o_kind,
  output logic [7:0] o_vec_lo,
  output logic       o_bflag,
  output logic       o_wr_inhibit
);

  typedef enum logic {ST_IDLE, ST_SEQ} state_t;
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_IRQ  = 2'd1,
    K_NMI  = 2'd2,
    K_RST  = 2'd3
  } kind_t;

  // Pin synchronisers; nmi_s3 holds the previous synchronised NMI level
  // for falling-edge detection.
  logic nmi_s1, nmi_s2, nmi_s3;
  logic irq_s1, irq_s2;
  logic nmi_edge;
  logic irq_req;
  logic hw_req;

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;
  kind_t  entry_kind;
  kind_t  vec_kind;
  logic   hw_q, hw_d;
  logic   bflag_q, bflag_d;
  logic   rst_pend_q, rst_pend_d;
  logic   nmi_pend_q, nmi_pend_d;
  logic   nmi_rearm_q, nmi_rearm_d;

`ifdef INTR_NMI_HIJACK_EN
  logic   vec_seen_q, vec_seen_d;
`else
  logic   unused_vec_cycle;
  assign unused_vec_cycle = i_vec_cycle;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nmi_s1 <= 1'b1;
      nmi_s2 <= 1'b1;
      nmi_s3 <= 1'b1;
      irq_s1 <= 1'b1;
      irq_s2 <= 1'b1;
    end else begin
      nmi_s1 <= i_nmi_n;
      nmi_s2 <= nmi_s1;
      nmi_s3 <= nmi_s2;
      irq_s1 <= i_irq_n;
      irq_s2 <= irq_s1;
    end
  end

  assign nmi_edge = nmi_s3 & ~nmi_s2;
  assign irq_req  = ~irq_s2 & ~i_iflag;
  assign hw_req   = rst_pend_q | nmi_pend_q | irq_req;

  // Kind that would be latched if an opcode fetch happened now.
  always_comb begin
    entry_kind = K_NONE;
    if (rst_pend_q)               entry_kind = K_RST;
    else if (nmi_pend_q)          entry_kind = K_NMI;
    else if (irq_req || i_brk_op) entry_kind = K_IRQ;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= K_NONE;
      hw_q        <= 1'b0;
      bflag_q     <= 1'b0;
      rst_pend_q  <= 1'b1;
      nmi_pend_q  <= 1'b0;
      nmi_rearm_q <= 1'b0;
`ifdef INTR_NMI_HIJACK_EN
      vec_seen_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      hw_q        <= hw_d;
      bflag_q     <= bflag_d;
      rst_pend_q  <= rst_pend_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_rearm_q <= nmi_rearm_d;
`ifdef INTR_NMI_HIJACK_EN
      vec_seen_q  <= vec_seen_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    hw_d        = hw_q;
    bflag_d     = bflag_q;
    rst_pend_d  = rst_pend_q;
    nmi_pend_d  = nmi_pend_q;
    nmi_rearm_d = nmi_rearm_q;
`ifdef INTR_NMI_HIJACK_EN
    vec_seen_d  = vec_seen_q;
`endif

    // Edge capture runs even while stalled. An edge during an NMI sequence
    // is parked in nmi_rearm so the end-of-sequence clear cannot swallow it.
    if (nmi_edge) begin
      if (state_q == ST_SEQ && kind_q == K_NMI) nmi_rearm_d = 1'b1;
      else                                      nmi_pend_d  = 1'b1;
    end

    if (i_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (i_sync && entry_kind != K_NONE) begin
            state_d = ST_SEQ;
            kind_d  = entry_kind;
            hw_d    = hw_req;
            bflag_d = i_brk_op & ~hw_req;
`ifdef INTR_NMI_HIJACK_EN
            vec_seen_d = 1'b0;
`endif
          end
        end
        ST_SEQ: begin
`ifdef INTR_NMI_HIJACK_EN
          if (kind_q == K_IRQ && nmi_pend_q && !vec_seen_q && !i_vec_cycle)
            kind_d = K_NMI;
          if (i_vec_cycle) vec_seen_d = 1'b1;
`endif
          if (i_vec_done) begin
            state_d = ST_IDLE;
            kind_d  = K_NONE;
            hw_d    = 1'b0;
            bflag_d = 1'b0;
            if (kind_q == K_RST) rst_pend_d = 1'b0;
            if (kind_q == K_NMI) begin
              nmi_pend_d  = nmi_edge | nmi_rearm_q;
              nmi_rearm_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign vec_kind = (state_q == ST_SEQ) ? kind_q : entry_kind;

  always_comb begin
    case (vec_kind)
      K_NMI:   o_vec_lo = 8'hFA;
      K_RST:   o_vec_lo = 8'hFC;
      default: o_vec_lo = 8'hFE;
    endcase
  end

  assign o_force_brk  = (state_q == ST_SEQ) ? hw_q : (i_sync & hw_req);
  assign o_kind       = kind_q;
  assign o_bflag      = bflag_q;
  assign o_wr_inhibit = (state_q == ST_SEQ) && (kind_q == K_RST);

endmodule

// File: tb/tb_intr_ctl.sv
// tb_intr_ctl -- scenario bench for intr_ctl. Expected output vectors
// {o_kind, o_vec_lo, o_force_brk, o_bflag, o_wr_inhibit} are queued when
// stimulus is applied and compared once the DUT has clocked it.
module tb_intr_ctl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_nmi_n;
  logic       i_irq_n;
  logic       i_iflag;
  logic       i_sync;
  logic       i_ready;
  logic       i_brk_op;
  logic       i_vec_cycle;
  logic       i_vec_done;
  logic       o_force_brk;
  logic [1:0] o_kind;
  logic [7:0] o_vec_lo;
  logic       o_bflag;
  logic       o_wr_inhibit;

  intr_ctl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_nmi_n      (i_nmi_n),
    .i_irq_n      (i_irq_n),
    .i_iflag      (i_iflag),
    .i_sync       (i_sync),
    .i_ready      (i_ready),
    .i_brk_op     (i_brk_op),
    .i_vec_cycle  (i_vec_cycle),
    .i_vec_done   (i_vec_done),
    .o_force_brk  (o_force_brk),
    .o_kind       (o_kind),
    .o_vec_lo     (o_vec_lo),
    .o_bflag      (o_bflag),
    .o_wr_inhibit (o_wr_inhibit)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] sb[$];
  string       sb_name[$];
  logic [12:0] obs;
  logic [12:0] exp_v;
  string       nm;

  assign obs = {o_kind, o_vec_lo, o_force_brk, o_bflag, o_wr_inhibit};

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push_exp(input string name, input logic [12:0] v);
    sb.push_back(v);
    sb_name.push_back(name);
  endtask

  task automatic nmi_pulse();
    i_nmi_n = 1'b0;
    tick();
    i_nmi_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_nmi_n = 1'b1; i_irq_n = 1'b1; i_iflag = 1'b1;
    i_sync = 1'b0; i_ready = 1'b1; i_brk_op = 1'b0;
    i_vec_cycle = 1'b0; i_vec_done = 1'b0;
    tick(3);
    n_checks++;
    if ({o_kind, o_force_brk, o_bflag, o_wr_inhibit} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 00000",
               {o_kind, o_force_brk, o_bflag, o_wr_inhibit});
    end
  endtask

  task automatic test_reset_seq();
    i_irq_n = 1'b0; i_iflag = 1'b0;
    i_rst_n = 1'b1;
    tick(3);
    i_sync = 1'b1;
    #1;
    n_checks++;
    if ({o_force_brk, o_vec_lo} !== {1'b1, 8'hFC}) begin
      n_fail++;
      $display("FAIL rst_lookahead: got %h expected 1fc", {o_force_brk, o_vec_lo});
    end
    push_exp("rst_entry", {2'd3, 8'hFC, 1'b1, 1'b0, 1'b1});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_irq_n = 1'b1; i_iflag = 1'b1;
    push_exp("rst_hold", {2'd3, 8'hFC, 1'b1, 1'b0, 1'b1});
    tick(2);
    i_vec_done = 1'b1;
    #1;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    push_exp("rst_exit", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_vec_done = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
  endtask

  task automatic test_irq();
    i_irq_n = 1'b0; i_iflag = 1'b0;
    tick(3);
    i_sync = 1'b1;
    push_exp("irq_entry", {2'd1, 8'hFE, 1'b1, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    // IRQ withdrawn mid-sequence must not abort it.
    i_irq_n = 1'b1;
    push_exp("irq_hold", {2'd1, 8'hFE, 1'b1, 1'b0, 1'b0});
    tick(3);
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    push_exp("irq_exit", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_vec_done = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    // Masked IRQ: no entry, no forced BRK.
    i_irq_n = 1'b0; i_iflag = 1'b1;
    tick(3);
    i_sync = 1'b1;
    #1;
    push_exp("irq_masked_sync", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    push_exp("irq_masked_idle", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_irq_n = 1'b1;
    tick(3);
  endtask

  task automatic test_brk();
    i_brk_op = 1'b1; i_sync = 1'b1;
    #1;
    push_exp("brk_lookahead", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    push_exp("brk_entry", {2'd1, 8'hFE, 1'b0, 1'b1, 1'b0});
    tick();
    i_brk_op = 1'b0; i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    push_exp("brk_exit", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_vec_done = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
  endtask

  task automatic test_nmi();
    nmi_pulse();
    tick(5);
    i_sync = 1'b1;
    #1;
    push_exp("nmi_lookahead", {2'd0, 8'hFA, 1'b1, 1'b0, 1'b0});
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    push_exp("nmi_entry", {2'd2, 8'hFA, 1'b1, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
    i_sync = 1'b1;
    push_exp("nmi_no_reentry", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
  endtask

  task automatic test_nmi_rearm();
    nmi_pulse();
    tick(4);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    nmi_pulse();
    tick(3);
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
    n_checks++;
    if (o_kind !== 2'd0) begin
      n_fail++;
      $display("FAIL rearm_exit: got kind %0d expected 0", o_kind);
    end
    i_sync = 1'b1;
    push_exp("rearm_entry", {2'd2, 8'hFA, 1'b1, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
    i_sync = 1'b1;
    push_exp("rearm_done", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
  endtask

  task automatic test_brk_then_nmi();
    i_brk_op = 1'b1; i_sync = 1'b1;
    tick();
    i_brk_op = 1'b0; i_sync = 1'b0;
    tick();
    nmi_pulse();
    tick(3);
`ifdef INTR_NMI_HIJACK_EN
    push_exp("hijack_kind", {2'd2, 8'hFA, 1'b0, 1'b1, 1'b0});
`else
    push_exp("brk_kind_fixed", {2'd1, 8'hFE, 1'b0, 1'b1, 1'b0});
`endif
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_cycle = 1'b1;
    tick();
    i_vec_cycle = 1'b0;
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
    n_checks++;
    if (o_kind !== 2'd0) begin
      n_fail++;
      $display("FAIL brk_nmi_exit: got kind %0d expected 0", o_kind);
    end
    i_sync = 1'b1;
`ifdef INTR_NMI_HIJACK_EN
    push_exp("hijack_no_reentry", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
`else
    push_exp("nmi_after_brk", {2'd2, 8'hFA, 1'b1, 1'b0, 1'b0});
`endif
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
  endtask

  task automatic test_ready_stall();
    i_irq_n = 1'b0; i_iflag = 1'b0;
    tick(3);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    i_irq_n = 1'b1; i_iflag = 1'b1;
    i_ready = 1'b0; i_vec_done = 1'b1; i_nmi_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp($sformatf("ready_hold_%0d", i), {2'd1, 8'hFE, 1'b1, 1'b0, 1'b0});
      tick();
      if (i == 0) i_nmi_n = 1'b1;
      exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    end
    i_ready = 1'b1;
    tick();
    i_vec_done = 1'b0;
    n_checks++;
    if (o_kind !== 2'd0) begin
      n_fail++;
      $display("FAIL ready_release: got kind %0d expected 0", o_kind);
    end
    // NMI edge taken while stalled must still be pending.
    i_sync = 1'b1;
    push_exp("ready_nmi_kept", {2'd2, 8'hFA, 1'b1, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
  endtask

  task automatic test_mid_reset();
    nmi_pulse();
    tick(4);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    nmi_pulse();
    tick(3);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_kind, o_force_brk, o_bflag, o_wr_inhibit} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_abandon: got %b expected 00000",
               {o_kind, o_force_brk, o_bflag, o_wr_inhibit});
    end
    tick(2);
    i_irq_n = 1'b0; i_iflag = 1'b0;
    i_rst_n = 1'b1;
    tick(3);
    i_sync = 1'b1;
    push_exp("rst_first_sync", {2'd3, 8'hFC, 1'b1, 1'b0, 1'b1});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
    i_irq_n = 1'b1; i_iflag = 1'b1;
    i_vec_done = 1'b1;
    tick();
    i_vec_done = 1'b0;
    tick(2);
    i_sync = 1'b1;
    push_exp("no_nmi_after_reset", {2'd0, 8'hFE, 1'b0, 1'b0, 1'b0});
    tick();
    i_sync = 1'b0;
    exp_v = sb.pop_front(); nm = sb_name.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_irq();
    test_brk();
    test_nmi();
    test_nmi_rearm();
    test_brk_then_nmi();
    test_ready_stall();
    test_mid_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/intr_ctl.md
INTR_CTL -- requirements
Module: intr_ctl

Interface
REQ-001 SHALL have: i_clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: i_nmi_n  input  1  NMI pin, asynchronous, falling-edge sensitive.
REQ-004 SHALL have: i_irq_n  input  1  IRQ pin, asynchronous, level sensitive.
REQ-005 SHALL have: i_iflag  input  1  processor status I bit (1 = IRQ masked).
REQ-006 SHALL have: i_sync  input  1  decoder opcode-fetch cycle.
REQ-007 SHALL have: i_ready  input  1  CPU READY; 0 stalls all sequence state.
REQ-008 SHALL have: i_brk_op  input  1  fetched opcode is 0x00 (valid with i_sync).
REQ-009 SHALL have: i_vec_cycle  input  1  decoder is driving the vector-low address cycle.
REQ-010 SHALL have: i_vec_done  input  1  decoder final cycle of the BRK/interrupt sequence.
REQ-011 SHALL have: o_force_brk  output  1  decoder substitutes opcode 0x00 and inhibits PC increment.
REQ-012 SHALL have: o_kind  output  2  active sequence: 0 none, 1 IRQ/BRK, 2 NMI, 3 RESET.
REQ-013 SHALL have: o_vec_lo  output  8  vector low address byte: 0xFE IRQ/BRK, 0xFA NMI, 0xFC RESET, 0xFE idle.
REQ-014 SHALL have: o_bflag  output  1  B bit value for pushed status.
REQ-015 SHALL have: o_wr_inhibit  output  1  forces read cycles for stack pushes (RESET only).

Function
REQ-016 i_nmi_n and i_irq_n SHALL pass through 2-flop synchronizers before use; sync flops reset to 1.
REQ-017 A 1->0 transition of synchronized NMI SHALL set nmi_pend; nmi_pend SHALL clear only on i_vec_done&i_ready with o_kind==2.
REQ-018 irq_req SHALL equal (synchronized IRQ == 0) && !i_iflag, evaluated combinationally, never latched.
REQ-019 rst_pend SHALL be 1 after reset and clear on i_vec_done&i_ready with o_kind==3.
REQ-020 States SHALL be IDLE and SEQ.
REQ-021 IDLE->SEQ on i_sync&i_ready when rst_pend|nmi_pend|irq_req|i_brk_op; kind latched by priority RESET > NMI > IRQ > BRK (BRK and IRQ both encode 1).
REQ-022 SEQ->IDLE on i_vec_done&i_ready; o_kind returns to 0 the following cycle.
REQ-023 o_force_brk SHALL be 1 in SEQ for hardware kinds, and combinationally in IDLE during i_sync when any hardware request is pending; 0 for software BRK.
REQ-024 o_bflag SHALL be 1 only for software BRK with no hardware request at entry; otherwise 0.
REQ-025 o_wr_inhibit SHALL equal (state==SEQ && o_kind==3).
REQ-026 o_vec_lo SHALL decode from o_kind in SEQ; in IDLE with a pending entry it SHALL reflect the kind about to be latched.
REQ-027 With i_ready=0 no state, pend or kind register SHALL change, except the synchronizers and NMI edge capture.
REQ-028 NMI edge during SEQ with o_kind==2 SHALL set nmi_pend again (serviced after current sequence).
REQ-029 irq_req deasserting during SEQ SHALL NOT abort the sequence.

Reset
REQ-030 On i_rst_n=0: state IDLE, o_kind 0, rst_pend 1, nmi_pend 0, sync flops 1, kind register 0.
REQ-031 Reset asserted mid-sequence SHALL abandon it immediately; no pending NMI survives reset.
REQ-032 First i_sync after reset release SHALL enter SEQ with kind RESET regardless of other requests.

Configuration
REQ-033 Macro INTR_NMI_HIJACK_EN: when defined, an NMI edge during SEQ with o_kind==1 before i_vec_cycle SHALL switch o_kind to 2 (o_vec_lo 0xFA, o_bflag unchanged) and that sequence SHALL clear nmi_pend; when undefined, kind is fixed at entry and NMI waits for the next i_sync.

Verification
REQ-034 Reset release, i_sync=1 -> SEQ, o_kind=3, o_vec_lo=0xFC, o_force_brk=1, o_wr_inhibit=1; i_vec_done -> o_kind=0 next cycle.
REQ-035 i_irq_n=0, i_iflag=0, i_sync -> o_kind=1, o_vec_lo=0xFE, o_bflag=0; repeat with i_iflag=1 -> stays IDLE.
REQ-036 i_brk_op=1 at i_sync, no IRQ -> o_kind=1, o_force_brk=0, o_bflag=1.
REQ-037 NMI pulse 1 cycle low while IDLE, i_sync 5 cycles later -> o_kind=2, o_vec_lo=0xFA; second sync without new edge -> IDLE.
REQ-038 Software BRK entered, NMI edge 2 cycles later before i_vec_cycle -> with INTR_NMI_HIJACK_EN o_vec_lo=0xFA; without it 0xFE then NMI at next sync.
REQ-039 i_ready=0 held 4 cycles during SEQ with i_vec_done=1 -> state and o_kind unchanged until i_ready=1.
